// File: rtl/parallel_to_serial_pkg.sv
// Shared constants for the ADC burst reader / SPI serializer.
package parallel_to_serial_pkg;

   // Serial word layout: {channel[1:0], 2'b00, data[11:0]}
   localparam int WORD_W   = 16;
   localparam int DATA_W   = 12;
   localparam int CH_MSB   = 15;
   localparam int CH_LSB   = 14;
   localparam int PAD_MSB  = 13;
   localparam int PAD_LSB  = 12;
   localparam int DATA_MSB = 11;
   localparam int DATA_LSB = 0;

   // Idle clkin cycles between the end of one word and the next channel read
   localparam int GAP_CYCLES = 2;

   // Controller states
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   function automatic logic [WORD_W-1:0] make_word(input logic [1:0]        ch,
                                                   input logic [DATA_W-1:0] data);
      logic [WORD_W-1:0] w;
      w = '0;
      w[CH_MSB:CH_LSB]     = ch;
      w[PAD_MSB:PAD_LSB]   = 2'b00;
      w[DATA_MSB:DATA_LSB] = data;
      return w;
   endfunction

endpackage

// File: rtl/parallel_to_serial_spi_shifter.sv
// 16-bit load/shift register with spi_clk divider (SPI mode 0, MSB first).
module spi_shifter
   import parallel_to_serial_pkg::*;
#(
   parameter int SCLK_DIV = 2
) (
   input  logic              clkin,
   input  logic              rst_bar,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   output logic              spi_clk,
   output logic              spi_mosi,
   output logic              spi_cs_bar,
   output logic              last
);

   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BIT_W = $clog2(WORD_W);

   logic [WORD_W-1:0] sreg;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              active;
   logic              sclk;
   logic              half_end;

   assign half_end = (div_cnt == DIV_W'(SCLK_DIV - 1));
   // Final falling edge of the word: the frame closes on this clkin edge
   assign last     = active & sclk & half_end & (bit_cnt == BIT_W'(WORD_W - 1));

   // Load a word, then toggle spi_clk every SCLK_DIV cycles; shift on falling edges
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         sreg    <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         active  <= 1'b0;
         sclk    <= 1'b0;
      end else if (load) begin
         sreg    <= word;
         div_cnt <= '0;
         bit_cnt <= '0;
         active  <= 1'b1;
         sclk    <= 1'b0;
      end else if (active) begin
         if (half_end) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk) begin
               sreg    <= {sreg[WORD_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                  active <= 1'b0;
               end
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   assign spi_clk    = sclk;
   assign spi_mosi   = active & sreg[WORD_W-1];
   assign spi_cs_bar = ~active;

endmodule

// File: rtl/parallel_to_serial.sv
// Reads NCH ADC channels over a parallel bus per burst and re-sends each
// sample as a 16-bit SPI word tagged with its channel number.
module parallel_to_serial
   import parallel_to_serial_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int DW       = 12,
   parameter int RD_LOW   = 2,
   parameter int SCLK_DIV = 2
) (
   input  logic          clkin,
   input  logic          rst_bar,
   input  logic          enable,
   input  logic [DW-1:0] db,
   output logic [NCH-1:0] cs_bar,
   output logic          rd_bar,
   output logic          spi_clk,
   output logic          spi_mosi,
   output logic          spi_cs_bar,
   output logic          busy,
   output logic          done
);

   localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CNT_MX = (RD_LOW > GAP_CYCLES) ? RD_LOW : GAP_CYCLES;
   localparam int CNT_W  = $clog2(CNT_MX + 1);

   logic [2:0]      state;
   logic [CH_W-1:0] ch;
   logic [CNT_W-1:0] cnt;
   logic            sync1, sync2, sync3;
   logic [1:0]      primed;
   logic            armed;
   logic            start;
   logic            load;
   logic            shift_last;
   logic [WORD_W-1:0] word;

   // Enable synchronizer and rising-edge detect. The flops reset to 0, so an
   // enable already high at reset release would look like an edge; armed only
   // sets once a genuinely sampled low has passed through the chain.
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         primed <= '0;
         armed  <= 1'b0;
      end else begin
         sync1  <= enable;
         sync2  <= sync1;
         sync3  <= sync2;
         primed <= {primed[0], 1'b1};
         armed  <= armed | (primed[1] & ~sync2);
      end
   end

   assign start = armed & sync2 & ~sync3;

   // Burst controller: READ -> SHIFT -> GAP per channel, DONE after the last
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         state <= ST_IDLE;
         ch    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               ch  <= '0;
               cnt <= '0;
               if (start) begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               if (cnt == CNT_W'(RD_LOW - 1)) begin
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (shift_last) begin
                  cnt   <= '0;
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                  cnt <= '0;
                  if (ch == CH_W'(NCH - 1)) begin
                     state <= ST_DONE;
                  end else begin
                     ch    <= ch + 1'b1;
                     state <= ST_READ;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Data is captured on the last rd_bar-low cycle, straight into the shifter
   assign load = (state == ST_READ) && (cnt == CNT_W'(RD_LOW - 1));
   assign word = make_word(2'(ch), 12'(db));

   // One-hot-low chip select for the channel being read
   always_comb begin
      cs_bar = '1;
      if (state == ST_READ) begin
         cs_bar[ch] = 1'b0;
      end
   end

   assign rd_bar = (state != ST_READ);
   assign busy   = (state != ST_IDLE);
   assign done   = (state == ST_DONE);

   spi_shifter #(
      .SCLK_DIV (SCLK_DIV)
   ) u_shifter (
      .clkin      (clkin),
      .rst_bar    (rst_bar),
      .load       (load),
      .word       (word),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_cs_bar (spi_cs_bar),
      .last       (shift_last)
   );

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: table of constant-db bursts plus
// hand sequences for incrementing data, ignored edges, glitches and reset.
module tb_parallel_to_serial;

   localparam int NCH      = 4;
   localparam int DW       = 12;
   localparam int RD_LOW   = 2;
   localparam int SCLK_DIV = 2;

   logic           clkin;
   logic           rst_bar;
   logic           enable;
   logic [DW-1:0]  db;
   logic [NCH-1:0] cs_bar;
   logic           rd_bar;
   logic           spi_clk;
   logic           spi_mosi;
   logic           spi_cs_bar;
   logic           busy;
   logic           done;

   parallel_to_serial #(
      .NCH      (NCH),
      .DW       (DW),
      .RD_LOW   (RD_LOW),
      .SCLK_DIV (SCLK_DIV)
   ) dut (
      .clkin      (clkin),
      .rst_bar    (rst_bar),
      .enable     (enable),
      .db         (db),
      .cs_bar     (cs_bar),
      .rd_bar     (rd_bar),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_cs_bar (spi_cs_bar),
      .busy       (busy),
      .done       (done)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   typedef struct {
      logic [11:0]       db;
      logic [3:0][15:0]  w;
   } vec_t;

   vec_t vecs [4];

   int unsigned checks;
   int unsigned errors;

   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];
   int          rd_len, rd_idx, frame_len, bit_n, done_cnt;
   logic [11:0] last_db;
   logic [15:0] cap;
   logic [3:0]  exp_cs;
   logic        p_sclk, p_mosi, p_rd, p_scs;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] bench_word(input int ch, input logic [11:0] d);
      logic [1:0] c;
      c = ch[1:0];
      return {c, 2'b00, d};
   endfunction

   // Monitor: sampled on the falling clkin edge, away from the active edge
   always @(negedge clkin) begin
      if (!rst_bar) begin
         rd_len    = 0;
         rd_idx    = 0;
         frame_len = 0;
         bit_n     = 0;
         cap       = '0;
         exp_q.delete();
         p_sclk = 1'b0;
         p_mosi = 1'b0;
         p_rd   = 1'b1;
         p_scs  = 1'b1;
      end else begin
         if (spi_clk) check("mosi_stable", spi_mosi, p_mosi);
         if (!rd_bar) begin
            if (rd_len == 0) check("ch_bound", rd_idx < NCH, 1);
            exp_cs = 4'hF;
            if (rd_idx < NCH) exp_cs[rd_idx] = 1'b0;
            check("cs_select", cs_bar, exp_cs);
            rd_len++;
            last_db = db;
         end else begin
            check("cs_idle", cs_bar, 4'hF);
         end
         if (rd_bar && !p_rd) begin
            check("rd_low_len", rd_len, RD_LOW);
            exp_q.push_back(bench_word(rd_idx, last_db));
            rd_idx++;
            rd_len = 0;
         end
         if (!spi_cs_bar) begin
            frame_len++;
            if (spi_clk && !p_sclk) begin
               cap = {cap[14:0], spi_mosi};
               bit_n++;
            end
         end
         if (spi_cs_bar && !p_scs) begin
            check("word_cycles", frame_len, 32 * SCLK_DIV);
            check("word_bits", bit_n, 16);
            check("word_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) check("word_value", cap, exp_q.pop_front());
            got_q.push_back(cap);
            frame_len = 0;
            bit_n     = 0;
         end
         if (done) done_cnt++;
         if (!busy) begin
            check("idle_outputs", {cs_bar, rd_bar, spi_clk, spi_mosi, spi_cs_bar, done},
                  {4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
            rd_idx = 0;
         end
         p_sclk = spi_clk;
         p_mosi = spi_mosi;
         p_rd   = rd_bar;
         p_scs  = spi_cs_bar;
      end
   end

   task automatic wait_done(input string name, input int max_cyc);
      int n;
      n = 0;
      while (!done && n < max_cyc) begin
         @(negedge clkin);
         n++;
      end
      check(name, done, 1);
      check("busy_at_done", busy, 1);
      @(negedge clkin);
      check("busy_fall", busy, 0);
   endtask

   task automatic wait_shift(input string name, input int words, input int max_cyc);
      int n;
      n = 0;
      while (!(got_q.size() == words && !spi_cs_bar && spi_clk) && n < max_cyc) begin
         @(negedge clkin);
         n++;
      end
      check(name, got_q.size() == words && !spi_cs_bar, 1);
   endtask

   task automatic pulse_start();
      enable = 1'b0;
      repeat (4) @(posedge clkin);
      #1 enable = 1'b1;
   endtask

   initial begin
      int n, div;
      logic [15:0] wa, wb;
      checks   = 0;
      errors   = 0;
      done_cnt = 0;
      rst_bar  = 1'b0;
      enable   = 1'b0;
      db       = '0;

      vecs[0] = '{db: 12'h5D2, w: {16'hC5D2, 16'h85D2, 16'h45D2, 16'h05D2}};
      vecs[1] = '{db: 12'h000, w: {16'hC000, 16'h8000, 16'h4000, 16'h0000}};
      vecs[2] = '{db: 12'hFFF, w: {16'hCFFF, 16'h8FFF, 16'h4FFF, 16'h0FFF}};
      vecs[3] = '{db: 12'hA5A, w: {16'hCA5A, 16'h8A5A, 16'h4A5A, 16'h0A5A}};

      repeat (3) @(posedge clkin);
      #1 check("reset_state", {cs_bar, rd_bar, spi_clk, spi_mosi, spi_cs_bar, busy, done},
               10'b1111100100);
      #2 rst_bar = 1'b1;
      repeat (4) @(posedge clkin);

      // Constant-db bursts from the table, including start latency
      for (int i = 0; i < 4; i++) begin
         got_q.delete();
         done_cnt = 0;
         db = vecs[i].db;
         @(posedge clkin);
         #1 enable = 1'b1;
         @(posedge clkin);
         @(posedge clkin);
         #1 check("start_pre", busy, 0);
         @(posedge clkin);
         #1 check("start_read", {busy, rd_bar, cs_bar}, {1'b1, 1'b0, 4'b1110});
         wait_done("burst_done", 400);
         enable = 1'b0;
         repeat (3) @(negedge clkin);
         check("word_count", got_q.size(), 4);
         for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) check("table_word", got_q[k], vecs[i].w[k]);
         end
         check("done_pulses", done_cnt, 1);
      end

      // db incrementing every 5 cycles: each word carries its last-low-cycle value
      got_q.delete();
      done_cnt = 0;
      db = 12'h100;
      pulse_start();
      n = 0;
      div = 0;
      while (!done && n < 600) begin
         @(posedge clkin);
         #1;
         n++;
         div++;
         if (div == 5) begin
            div = 0;
            db = db + 1'b1;
         end
      end
      check("inc_done", done, 1);
      repeat (3) @(negedge clkin);
      check("inc_word_count", got_q.size(), 4);
      check("inc_done_pulses", done_cnt, 1);
      if (got_q.size() == 4) begin
         wa = got_q[0];
         wb = got_q[3];
         check("inc_db_advanced", wb[11:0] > wa[11:0], 1);
      end

      // Edge during channel 1 SHIFT ignored; enable held high across IDLE
      got_q.delete();
      done_cnt = 0;
      db = 12'h3C7;
      pulse_start();
      repeat (10) @(posedge clkin);
      #1 enable = 1'b0;
      wait_shift("ch1_shift_reached", 1, 500);
      enable = 1'b1;
      wait_done("ignored_edge_done", 600);
      repeat (40) @(negedge clkin);
      check("held_high_no_restart", busy, 0);
      check("ignored_word_count", got_q.size(), 4);
      check("ignored_done_pulses", done_cnt, 1);
      got_q.delete();
      done_cnt = 0;
      pulse_start();
      wait_done("restart_done", 600);
      repeat (3) @(negedge clkin);
      check("restart_word_count", got_q.size(), 4);

      // Sub-cycle glitch between clock edges produces no burst
      got_q.delete();
      enable = 1'b0;
      repeat (4) @(posedge clkin);
      #2 enable = 1'b1;
      #4 enable = 1'b0;
      repeat (10) @(negedge clkin);
      check("glitch_no_busy", busy, 0);
      check("glitch_no_words", got_q.size(), 0);

      // Reset during channel 2 SHIFT, enable held high through release
      got_q.delete();
      done_cnt = 0;
      db = 12'h2B4;
      pulse_start();
      wait_shift("ch2_shift_reached", 2, 800);
      @(posedge clkin);
      #3 rst_bar = 1'b0;
      #1 check("reset_async", {cs_bar, rd_bar, spi_clk, spi_mosi, spi_cs_bar, busy, done},
               10'b1111100100);
      repeat (3) @(posedge clkin);
      #3 rst_bar = 1'b1;
      repeat (30) @(negedge clkin);
      check("no_burst_after_reset", busy, 0);
      check("no_done_after_reset", done_cnt, 0);
      check("reset_word_count", got_q.size(), 2);
      got_q.delete();
      pulse_start();
      wait_done("post_reset_done", 600);
      repeat (3) @(negedge clkin);
      check("post_reset_words", got_q.size(), 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter NCH, default 4: number of ADC channels read per burst.
REQ-002 Parameter DW, default 12: ADC data bus width.
REQ-003 Parameter RD_LOW, default 2: clkin cycles that cs_bar/rd_bar stay low per channel read.
REQ-004 Parameter SCLK_DIV, default 2: clkin cycles per spi_clk half-period.
REQ-005 clkin  in  1  single system clock; all logic rises on clkin.
REQ-006 rst_bar  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  data-ready from the conversion driver; asynchronous to clkin.
REQ-008 db  in  DW  ADC parallel data bus.
REQ-009 cs_bar  out  NCH  per-channel ADC chip select, active low, one-hot-low.
REQ-010 rd_bar  out  1  ADC read strobe, active low.
REQ-011 spi_clk  out  1  serial clock, idle low (SPI mode 0).
REQ-012 spi_mosi  out  1  serial data, MSB first.
REQ-013 spi_cs_bar  out  1  serial frame select, low for exactly one 16-bit word.
REQ-014 busy  out  1  high from burst start until return to IDLE.
REQ-015 done  out  1  one-cycle pulse at burst completion.

Function
REQ-016 enable SHALL pass a 2-flop synchronizer; a burst starts on the synchronized rising edge (start = 3 clkin cycles after enable rises).
REQ-017 States SHALL be IDLE, READ, SHIFT, GAP, DONE; IDLE->READ on start with channel index ch=0.
REQ-018 READ: cs_bar[ch]=0 and rd_bar=0 for RD_LOW cycles, all other cs_bar bits 1; db latched on the last low cycle; then cs_bar/rd_bar return high together and state goes SHIFT.
REQ-019 Serial word SHALL be 16 bits = {ch[1:0], 2'b00, latched db[11:0]}, shifted MSB first.
REQ-020 SHIFT: spi_cs_bar=0; spi_mosi valid one half-period before each spi_clk rising edge and changes only while spi_clk low; 16 spi_clk pulses; word lasts 32*SCLK_DIV clkin cycles.
REQ-021 After the 16th falling edge spi_clk stays low, spi_cs_bar returns high, state goes GAP for 2 cycles.
REQ-022 GAP: if ch<NCH-1, ch increments and state goes READ; else DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE; busy falls the same cycle as the return to IDLE.
REQ-024 Rising edges of enable while busy=1 SHALL be ignored (no queueing).
REQ-025 ch wraps only via IDLE; no burst ever reads more than NCH channels.
REQ-026 In IDLE: cs_bar all 1, rd_bar=1, spi_clk=0, spi_mosi=0, spi_cs_bar=1, busy=0, done=0.

Reset
REQ-027 rst_bar low SHALL immediately force state IDLE, ch=0, shift register 0, synchronizer flops 0 and all outputs to REQ-026 values, including mid-burst.
REQ-028 After reset release no burst starts unless enable shows a new 0->1 transition.

Structure
REQ-029 Shared package SHALL hold the state enumeration, word width constant (16) and the word-format field positions.
REQ-030 One sub-module, spi_shifter (16-bit load/shift with spi_clk divider), is natural; the FSM and ADC read strobes stay in the top module.

Verification
REQ-031 Reset then enable pulse with db=12'h5D2 constant -> four READ strobes on cs_bar[0..3] in order; words 0x05D2, 0x45D2, 0x85D2, 0xC5D2 on spi_mosi; one done pulse.
REQ-032 db incrementing every 5 clkin cycles -> each word carries the db value present on the last rd_bar-low cycle of its channel.
REQ-033 Second enable edge during SHIFT of channel 1 -> ignored; exactly 4 words emitted; next edge after IDLE starts a new burst.
REQ-034 rst_bar asserted during SHIFT of channel 2 -> all outputs idle within the same cycle; no done pulse.
REQ-035 enable glitch shorter than 1 clkin cycle that misses both sync flops -> no burst; enable held high across IDLE -> only one burst.
REQ-036 Timing check at defaults -> rd_bar low exactly 2 cycles; 64 clkin cycles per word; spi_mosi stable across every spi_clk rising edge.
